// File: rtl/mul_csa_accum.sv
// mul_csa_accum: sequential 3:2 carry-save accumulator that resolves a partial-product stream into one selected product half
// Optional feature: define MUL_CSA_ACC_FLUSH_EN to add the flush port.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mul_csa_accum #(
    parameter int WORD_WIDTH = `WORD_WIDTH,
    parameter int PPW        = 2 * (WORD_WIDTH + 1),
    parameter int MAX_PP     = 17,
    parameter int TAG_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef MUL_CSA_ACC_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  pp_valid,
    output logic                  pp_ready,
    input  logic [PPW-1:0]        pp_data,
    input  logic                  pp_last,
    input  logic                  pp_hi_sel,
    input  logic [TAG_W-1:0]      pp_tag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WORD_WIDTH-1:0] res_data,
    output logic [TAG_W-1:0]      res_tag,
    output logic                  res_err
);
    localparam int CW = $clog2(MAX_PP + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t                  st, nst;
    logic [PPW-1:0]          sum, carry;
    logic [2*WORD_WIDTH-1:0] prod;
    logic [CW-1:0]           cnt;
    logic [TAG_W-1:0]        tag;
    logic                    hi_sel, err, fl, accept, term;

`ifdef MUL_CSA_ACC_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif

    assign accept = pp_valid & pp_ready;
    // the beat about to be accepted is the last one this op may take
    assign term = (cnt == CW'(MAX_PP - 1));

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) st <= IDLE;
        else        st <= nst;
    end

    // next-state: collect beats, one resolve cycle, then hold until the consumer takes the result
    always_comb begin
        nst = st;
        if (fl) nst = IDLE;
        else begin
            case (st)
                IDLE:    if (accept) nst = pp_last ? RESOLVE : ACCUM;
                ACCUM:   if (accept && (pp_last || term)) nst = RESOLVE;
                RESOLVE: nst = DONE;
                DONE:    if (res_ready) nst = IDLE;
                default: nst = IDLE;
            endcase
        end
    end

    // outputs decoded from state and the registered op context
    always_comb begin
        pp_ready  = (st == IDLE) || (st == ACCUM);
        res_valid = (st == DONE);
        res_data  = hi_sel ? prod[2*WORD_WIDTH-1:WORD_WIDTH] : prod[WORD_WIDTH-1:0];
        res_tag   = tag;
        res_err   = err;
    end

    // datapath: load first beat, compress later beats 3:2, resolve once with a single carry-propagate add
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum    <= '0;
            carry  <= '0;
            prod   <= '0;
            cnt    <= '0;
            tag    <= '0;
            hi_sel <= 1'b0;
            err    <= 1'b0;
        end else if (fl) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            case (st)
                IDLE: if (accept) begin
                    sum    <= pp_data;
                    carry  <= '0;
                    cnt    <= CW'(1);
                    hi_sel <= pp_hi_sel;
                    tag    <= pp_tag;
                    err    <= 1'b0;
                end
                ACCUM: if (accept) begin
                    sum   <= sum ^ carry ^ pp_data;
                    carry <= ((sum & carry) | (sum & pp_data) | (carry & pp_data)) << 1;
                    cnt   <= cnt + 1'b1;
                    err   <= term & ~pp_last;
                end
                RESOLVE: prod <= (2*WORD_WIDTH)'(sum + carry);
                DONE:    if (res_ready) err <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_csa_accum.sv
// tb_mul_csa_accum: directed and randomized checks of mul_csa_accum against an arithmetic sum-of-beats model
module tb_mul_csa_accum;
    localparam int W = 32, PPW = 66, MAX_PP = 17, TW = 6;

    logic clk = 1'b0, rst_n = 1'b0, pp_valid = 1'b0, pp_last = 1'b0, pp_hi_sel = 1'b0, res_ready = 1'b0;
    logic pp_ready, res_valid, res_err;
    logic [PPW-1:0] pp_data = '0;
    logic [TW-1:0] pp_tag = '0, res_tag;
    logic [W-1:0] res_data;
`ifdef MUL_CSA_ACC_FLUSH_EN
    logic flush = 1'b0;
`endif
    int checks = 0, errors = 0;
    logic [PPW-1:0] beats [MAX_PP];

    mul_csa_accum dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MUL_CSA_ACC_FLUSH_EN
        .flush(flush),
`endif
        .pp_valid(pp_valid), .pp_ready(pp_ready), .pp_data(pp_data), .pp_last(pp_last),
        .pp_hi_sel(pp_hi_sel), .pp_tag(pp_tag), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_err(res_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PPW-1:0] rnd66();
        return PPW'({$urandom, $urandom, $urandom});
    endfunction

    // drives one op from IDLE through handshake; expected result is the plain sum of beats mod 2^66
    task automatic run_op(input int n, input logic hi, input logic [TW-1:0] tag, input logic last,
                          input int stall, input int bub, input string name);
        logic [PPW-1:0] acc;
        logic [W-1:0] exp_d;
        logic exp_e;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && bub > 0 && $urandom_range(0, 99) < bub) begin
                pp_valid = 1'b0; pp_last = 1'b1; pp_data = rnd66();
                step;
            end
            pp_valid = 1'b1; pp_data = beats[i]; pp_last = last && (i == n - 1);
            pp_hi_sel = (i == 0) ? hi : ~hi;
            pp_tag = (i == 0) ? tag : ~tag;
            checks++;
            if (pp_ready !== 1'b1) begin errors++; $display("FAIL %s_beat_ready beat %0d got %b want 1", name, i, pp_ready); end
            step;
            acc = acc + beats[i];
        end
        pp_valid = 1'b0; pp_last = 1'b0; pp_data = rnd66();
        exp_d = hi ? acc[2*W-1:W] : acc[W-1:0];
        exp_e = !last && n == MAX_PP;
        checks++;
        if (pp_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL %s_resolve got ready=%b valid=%b want 0 0", name, pp_ready, res_valid);
        end
        step;
        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_d || res_tag !== tag || res_err !== exp_e || pp_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_done cyc %0d got v=%b d=%h t=%h e=%b r=%b want v=1 d=%h t=%h e=%b r=0",
                         name, s, res_valid, res_data, res_tag, res_err, pp_ready, exp_d, tag, exp_e);
            end
            if (s < stall) begin
                pp_valid = 1'b1; pp_last = 1'b1; pp_data = rnd66();
                step;
            end
        end
        pp_valid = 1'b0; res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || res_err !== 1'b0 || pp_ready !== 1'b1) begin
            errors++; $display("FAIL %s_after_hs got v=%b e=%b r=%b want 0 0 1", name, res_valid, res_err, pp_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step;
        checks++;
        if (pp_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== '0 || res_tag !== '0 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL reset got r=%b v=%b d=%h t=%h e=%b want 1 0 0 0 0", pp_ready, res_valid, res_data, res_tag, res_err);
        end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_single;
        beats[0] = 66'd5;
        run_op(1, 1'b0, 6'h11, 1'b1, 0, 0, "single");
    endtask

    task automatic test_three_beats;
        beats[0] = 66'd3; beats[1] = 66'd5; beats[2] = 66'd7;
        run_op(3, 1'b0, 6'h2A, 1'b1, 0, 0, "three");
    endtask

    task automatic test_negative;
        beats[0] = -66'sd12; beats[1] = '0;
        run_op(2, 1'b1, 6'h05, 1'b1, 0, 0, "neg_hi");
        beats[0] = -66'sd12; beats[1] = '0;
        run_op(2, 1'b0, 6'h06, 1'b1, 0, 0, "neg_lo");
    endtask

    task automatic test_back_to_back;
        beats[0] = 66'h1_2345_6789; beats[1] = 66'h3_0000_0001;
        run_op(2, 1'b1, 6'h33, 1'b1, 5, 0, "stall");
        beats[0] = 66'hABCD;
        run_op(1, 1'b0, 6'h34, 1'b1, 0, 0, "b2b");
    endtask

    task automatic test_max_beats;
        for (int i = 0; i < MAX_PP; i++) beats[i] = 66'd1;
        run_op(MAX_PP, 1'b0, 6'h3F, 1'b0, 1, 0, "max_pp");
        beats[0] = 66'd4;
        run_op(1, 1'b0, 6'h01, 1'b1, 0, 0, "after_err");
    endtask

    task automatic test_midop_reset;
        pp_valid = 1'b1; pp_last = 1'b0; pp_hi_sel = 1'b0; pp_tag = 6'h15;
        for (int i = 0; i < 3; i++) begin
            pp_data = rnd66();
            step;
        end
        rst_n = 1'b0;
        step;
        rst_n = 1'b1; pp_valid = 1'b0;
        checks++;
        if (pp_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL midrst got r=%b v=%b want 1 0", pp_ready, res_valid);
        end
        repeat (4) begin
            step;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_quiet got v=%b want 0", res_valid); end
        end
        beats[0] = 66'd9;
        run_op(1, 1'b0, 6'h09, 1'b1, 0, 0, "post_rst");
    endtask

`ifdef MUL_CSA_ACC_FLUSH_EN
    task automatic test_flush;
        pp_valid = 1'b1; pp_last = 1'b0; pp_hi_sel = 1'b0; pp_tag = 6'h21;
        repeat (2) begin
            pp_data = rnd66();
            step;
        end
        flush = 1'b1; pp_data = rnd66(); pp_last = 1'b1;
        step;
        flush = 1'b0; pp_valid = 1'b0;
        checks++;
        if (pp_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL flush_accum got r=%b v=%b want 1 0", pp_ready, res_valid);
        end
        beats[0] = 66'd9;
        run_op(1, 1'b0, 6'h22, 1'b1, 0, 0, "post_flush");
        pp_valid = 1'b1; pp_last = 1'b1; pp_data = 66'd7;
        step;
        pp_valid = 1'b0;
        step;
        flush = 1'b1; res_ready = 1'b1;
        step;
        flush = 1'b0; res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || pp_ready !== 1'b1) begin
            errors++; $display("FAIL flush_done got v=%b r=%b want 0 1", res_valid, pp_ready);
        end
        beats[0] = 66'd3;
        run_op(1, 1'b0, 6'h23, 1'b1, 0, 0, "post_flush2");
    endtask
`endif

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            int n;
            logic last;
            n = $urandom_range(1, MAX_PP);
            last = (n < MAX_PP) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) beats[i] = rnd66();
            run_op(n, 1'($urandom_range(0, 1)), 6'($urandom), last, $urandom_range(0, 3), 30, "rand");
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_three_beats;
        test_negative;
        test_back_to_back;
        test_max_beats;
        test_midop_reset;
`ifdef MUL_CSA_ACC_FLUSH_EN
        test_flush;
`endif
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
